ddr2_ring_scheduler: RTL and testbench
======================================

Name: ddr2_ring_scheduler

Overview:
- Scheduler that sits above the DDR2 burst read/write engine and shares the single MCB p0 command port between the input-FIFO drain path (writes) and the output-FIFO fill path (reads).
- Decides which burst runs next and hands out the burst byte address.
- Manages the SDRAM as a circular buffer with wrap-around, occupancy tracking, overflow flagging, write/read fairness and a burst watchdog.

Parameters:
- BURST_LEN, 2, 32-bit words per burst; must be even; burst stride = 4*BURST_LEN bytes.
- FIFO_SIZE, 2048, depth of the output FIFO in words.
- RING_BYTES, 134217728, ring size in bytes; power of two; multiple of the stride.
- MAX_WR_STREAK, 16, consecutive write grants allowed before a pending read is forced.
- TIMEOUT, 1023, cycles allowed between a go pulse and burst_done.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- calib_done  in  1  MCB calibration complete
- writes_en  in  1  host write enable (raw; registered internally)
- reads_en  in  1  host read enable (raw; registered internally)
- ring_clear  in  1  one-cycle request to empty the ring
- ib_count  in  11  input FIFO word count
- ob_count  in  11  output FIFO word count
- go_wr  out  1  one-cycle pulse: start write burst at go_addr
- go_rd  out  1  one-cycle pulse: start read burst at go_addr
- go_addr  out  30  burst byte address, valid when go_wr or go_rd is high
- burst_done  in  1  one-cycle pulse from the burst engine at end of burst
- busy  out  1  burst in flight
- cmd_byte_addr_wr  out  30  next write byte address
- cmd_byte_addr_rd  out  30  next read byte address
- occupancy  out  30  bytes written and not yet granted for read
- overflow  out  1  sticky: write eligible but ring full
- timeout_err  out  1  sticky: burst_done missing for TIMEOUT cycles

Behaviour:
- Reset (async, active-high):
  - All outputs 0, state S_IDLE, streak and watchdog counters 0.
  - Registered enables cleared; pending-clear flag cleared.
- writes_en and reads_en are registered once (we_q, re_q) before use.
- Write eligibility (wr_ok), all required:
  - calib_done, we_q, ib_count >= BURST_LEN
  - occupancy <= RING_BYTES - 4*BURST_LEN
- Read eligibility (rd_ok), all required:
  - calib_done, re_q, ob_count < FIFO_SIZE-1-BURST_LEN
  - occupancy >= 4*BURST_LEN
- Overflow: in S_IDLE, if calib_done and we_q and ib_count >= BURST_LEN but the ring is full, set overflow. It is cleared only by reset or ring_clear. No write is issued; data stays in the input FIFO.
- Arbitration, evaluated in S_IDLE only:
  - Both eligible: write wins unless wr_streak >= MAX_WR_STREAK, in which case read wins.
  - Write grant: wr_streak increments, saturating.
  - Read grant: wr_streak cleared.
  - Idle cycle with no read eligible: wr_streak cleared.
- States:
  - S_IDLE: on a write grant, register go_wr=1, go_addr=cmd_byte_addr_wr, advance cmd_byte_addr_wr, go to S_WR. On a read grant, register go_rd=1, go_addr=cmd_byte_addr_rd, advance cmd_byte_addr_rd, occupancy -= 4*BURST_LEN, go to S_RD.
  - S_WR: on burst_done, occupancy += 4*BURST_LEN and go to S_IDLE. Occupancy is updated on completion so a read never overtakes unwritten data.
  - S_RD: on burst_done, go to S_IDLE.
- Address advance: addr <= (addr + 4*BURST_LEN) mod RING_BYTES. At RING_BYTES - stride the pointer wraps to 0.
- Timing:
  - Go pulses last exactly one cycle; busy=1 in S_WR and S_RD.
  - burst_done at edge N returns the block to S_IDLE; the earliest next go is at edge N+1.
  - burst_done seen in S_IDLE is ignored.
- Watchdog:
  - Counter cleared on every go pulse; increments in S_WR and S_RD.
  - When it reaches TIMEOUT: set timeout_err and return to S_IDLE.
  - Pointers are not rolled back; occupancy is not credited for a timed-out write.
- ring_clear:
  - In S_IDLE it takes effect at the next edge: both pointers, occupancy and overflow go to 0, and no grant is issued that cycle.
  - While busy it is latched as pending and applied on the edge after burst_done, before any new grant.
- Simultaneous ring_clear and reset: reset dominates.
- Deasserting calib_done mid-burst does not abort the burst; it only blocks new grants.

Decomposition:
- Shared package ddr2_pkg:
  - state encodings S_IDLE/S_WR/S_RD
  - BURST_STRIDE = 4*BURST_LEN
  - address width 30 and the FIFO count width 11
- One natural sub-module, ddr2_ring_ptr: a wrapping byte-address pointer with advance and clear, instantiated twice (write and read).
- Arbitration, occupancy and the watchdog stay in the top module.

Test Plan:
- Write-only:
  - Stimulus: calib_done=1, writes_en=1, ib_count=100; burst_done returned 4 cycles after each go_wr.
  - Response: go_addr sequence 0, 8, 16, ...; occupancy rises by 8 per burst_done; exactly one idle cycle between bursts.
- Fairness:
  - Stimulus: both paths eligible continuously, MAX_WR_STREAK=16.
  - Response: 16 go_wr, then 1 go_rd at address 0, then writes resume.
- Wrap:
  - Stimulus: RING_BYTES=64; fill with 8 writes, then 8 reads.
  - Response: write address wraps 56 -> 0; occupancy 64 -> 0; the 9th write is blocked until the first read grant.
- Overflow:
  - Stimulus: ring full, reads_en=0, ib_count=10.
  - Response: overflow=1 and no go_wr; a ring_clear pulse clears overflow and occupancy and zeroes both pointers.
- Watchdog:
  - Stimulus: issue go_rd and withhold burst_done, TIMEOUT=1023.
  - Response: timeout_err=1 after 1023 cycles; state S_IDLE; busy=0.
- Async reset mid-burst:
  - Stimulus: assert reset between clock edges while in S_WR.
  - Response: all outputs 0 immediately, without waiting for a clock edge; after release, the first go_wr has go_addr=0.

Source files
------------

// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 ring scheduler slice.
//   ADDR_W       : width of SDRAM byte addresses and the occupancy count
//   CNT_W        : width of the input/output FIFO word counts
//   state_t      : scheduler states S_IDLE / S_WR / S_RD
//   burst_stride : bytes covered by one burst of 32-bit words
package ddr2_pkg;

    localparam int ADDR_W = 30;
    localparam int CNT_W  = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    function automatic int burst_stride(input int burst_len);
        return 4 * burst_len;
    endfunction

    // Stride for the default burst length of two words.
    localparam int BURST_STRIDE = burst_stride(2);

endpackage

// File: rtl/ddr2_ring_scheduler_if.sv
// Bus between the host/FIFO/burst-engine side and the ring scheduler.
//   master : drives enables, FIFO counts, ring_clear and burst_done;
//            observes go pulses, pointers and status
//   slave  : the scheduler itself
interface ddr2_ring_scheduler_if;

    logic                        calib_done;
    logic                        writes_en;
    logic                        reads_en;
    logic                        ring_clear;
    logic [ddr2_pkg::CNT_W-1:0]  ib_count;
    logic [ddr2_pkg::CNT_W-1:0]  ob_count;
    logic                        go_wr;
    logic                        go_rd;
    logic [ddr2_pkg::ADDR_W-1:0] go_addr;
    logic                        burst_done;
    logic                        busy;
    logic [ddr2_pkg::ADDR_W-1:0] cmd_byte_addr_wr;
    logic [ddr2_pkg::ADDR_W-1:0] cmd_byte_addr_rd;
    logic [ddr2_pkg::ADDR_W-1:0] occupancy;
    logic                        overflow;
    logic                        timeout_err;

    modport master (
        output calib_done, writes_en, reads_en, ring_clear,
        output ib_count, ob_count, burst_done,
        input  go_wr, go_rd, go_addr, busy,
        input  cmd_byte_addr_wr, cmd_byte_addr_rd, occupancy,
        input  overflow, timeout_err
    );

    modport slave (
        input  calib_done, writes_en, reads_en, ring_clear,
        input  ib_count, ob_count, burst_done,
        output go_wr, go_rd, go_addr, busy,
        output cmd_byte_addr_wr, cmd_byte_addr_rd, occupancy,
        output overflow, timeout_err
    );

endinterface

// File: rtl/ddr2_ring_ptr.sv
// Wrapping SDRAM byte-address pointer for the circular buffer.
//   clk, reset : clock, asynchronous active-high reset
//   adv        : step the pointer by one burst stride
//   clr        : return the pointer to 0 (wins over adv)
//   addr       : current byte address, always a multiple of STRIDE
module ddr2_ring_ptr
    import ddr2_pkg::*;
#(
    parameter int STRIDE     = 8,
    parameter int RING_BYTES = 134217728
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
    // Ring size is a power of two, so the modulo is a mask.
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(RING_BYTES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (adv) begin
            addr <= (addr + STEP) & MASK;
        end
    end

endmodule

// File: rtl/ddr2_ring_scheduler.sv
// Shares the MCB p0 command port between input-FIFO drain (write bursts)
// and output-FIFO fill (read bursts), treating the SDRAM as a ring buffer.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of ddr2_ring_scheduler_if
//                in : calib_done, writes_en, reads_en, ring_clear,
//                     ib_count, ob_count, burst_done
//                out: go_wr, go_rd, go_addr, busy, cmd_byte_addr_wr,
//                     cmd_byte_addr_rd, occupancy, overflow, timeout_err
module ddr2_ring_scheduler
    import ddr2_pkg::*;
#(
    parameter int BURST_LEN     = 2,
    parameter int FIFO_SIZE     = 2048,
    parameter int RING_BYTES    = 134217728,
    parameter int MAX_WR_STREAK = 16,
    parameter int TIMEOUT       = 1023
) (
    input logic                  clk,
    input logic                  reset,
    ddr2_ring_scheduler_if.slave bus
);

    localparam int STRIDE = burst_stride(BURST_LEN);
    localparam int SW     = $clog2(MAX_WR_STREAK + 1);
    localparam int WW     = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] FULL_LIM   = ADDR_W'(RING_BYTES - STRIDE);
    localparam logic [CNT_W-1:0]  IB_MIN     = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  OB_LIM     = CNT_W'(FIFO_SIZE - 1 - BURST_LEN);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_WR_STREAK);
    localparam logic [WW-1:0]     WD_LAST    = WW'(TIMEOUT - 1);

    state_t            state, state_n;
    logic              we_q, re_q;
    logic              clr_pend;
    logic [SW-1:0]     wr_streak;
    logic [WW-1:0]     wd_cnt;
    logic [ADDR_W-1:0] occupancy;
    logic [ADDR_W-1:0] go_addr;
    logic [ADDR_W-1:0] addr_wr, addr_rd;
    logic              go_wr, go_rd;
    logic              overflow, timeout_err;

    logic              wr_req, wr_room, wr_ok, rd_ok;
    logic              do_clear;
    logic              grant_wr, grant_rd, wd_expire;

    // A write wants to go; it may only go if a whole burst still fits.
    assign wr_req  = bus.calib_done && we_q && (bus.ib_count >= IB_MIN);
    assign wr_room = (occupancy <= FULL_LIM);
    assign wr_ok   = wr_req && wr_room;
    assign rd_ok   = bus.calib_done && re_q && (bus.ob_count < OB_LIM)
                     && (occupancy >= STRIDE_A);

    // A clear requested during a burst waits for the first idle edge and
    // pre-empts any grant on that edge.
    assign do_clear = (state == S_IDLE) && (bus.ring_clear || clr_pend);

    always_comb begin
        state_n   = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        wd_expire = 1'b0;
        case (state)
            S_IDLE: begin
                if (!do_clear) begin
                    if (wr_ok && (!rd_ok || (wr_streak < STREAK_MAX))) begin
                        grant_wr = 1'b1;
                        state_n  = S_WR;
                    end else if (rd_ok) begin
                        grant_rd = 1'b1;
                        state_n  = S_RD;
                    end
                end
            end
            S_WR, S_RD: begin
                if (bus.burst_done) begin
                    state_n = S_IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            clr_pend    <= 1'b0;
            wr_streak   <= '0;
            wd_cnt      <= '0;
            occupancy   <= '0;
            go_wr       <= 1'b0;
            go_rd       <= 1'b0;
            go_addr     <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            we_q  <= bus.writes_en;
            re_q  <= bus.reads_en;
            go_wr <= grant_wr;
            go_rd <= grant_rd;

            if (grant_wr) begin
                go_addr <= addr_wr;
            end else if (grant_rd) begin
                go_addr <= addr_rd;
            end

            if (state != S_IDLE && bus.ring_clear) begin
                clr_pend <= 1'b1;
            end else if (do_clear) begin
                clr_pend <= 1'b0;
            end

            // Reads debit at grant; writes credit only on completion so a
            // read can never be granted over data not yet in SDRAM.
            if (do_clear) begin
                occupancy <= '0;
            end else if (grant_rd) begin
                occupancy <= occupancy - STRIDE_A;
            end else if (state == S_WR && bus.burst_done) begin
                occupancy <= occupancy + STRIDE_A;
            end

            if (do_clear) begin
                overflow <= 1'b0;
            end else if (state == S_IDLE && wr_req && !wr_room) begin
                overflow <= 1'b1;
            end

            if (state == S_IDLE) begin
                if (grant_wr) begin
                    if (wr_streak != STREAK_MAX) begin
                        wr_streak <= wr_streak + 1'b1;
                    end
                end else if (grant_rd || !rd_ok) begin
                    wr_streak <= '0;
                end
            end

            if (grant_wr || grant_rd) begin
                wd_cnt <= '0;
            end else if (state != S_IDLE) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (wd_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

    ddr2_ring_ptr #(
        .STRIDE     (STRIDE),
        .RING_BYTES (RING_BYTES)
    ) u_ptr_wr (
        .clk   (clk),
        .reset (reset),
        .adv   (grant_wr),
        .clr   (do_clear),
        .addr  (addr_wr)
    );

    ddr2_ring_ptr #(
        .STRIDE     (STRIDE),
        .RING_BYTES (RING_BYTES)
    ) u_ptr_rd (
        .clk   (clk),
        .reset (reset),
        .adv   (grant_rd),
        .clr   (do_clear),
        .addr  (addr_rd)
    );

    assign bus.go_wr            = go_wr;
    assign bus.go_rd            = go_rd;
    assign bus.go_addr          = go_addr;
    assign bus.busy             = (state != S_IDLE);
    assign bus.cmd_byte_addr_wr = addr_wr;
    assign bus.cmd_byte_addr_rd = addr_rd;
    assign bus.occupancy        = occupancy;
    assign bus.overflow         = overflow;
    assign bus.timeout_err      = timeout_err;

endmodule

// File: tb/tb_ddr2_ring_scheduler.sv
// Bench for ddr2_ring_scheduler: small ring (256 bytes, stride 8) so the
// wrap and full conditions are reachable, default fairness and watchdog.
module tb_ddr2_ring_scheduler;
    import ddr2_pkg::*;

    localparam int RING = 256;
    localparam int TMO  = 1023;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
    } go_t;

    typedef struct {
        bit calib;
        bit we;
        bit re;
        int ib;
        int ob;
        int fill;
        int kind;   // 0 none, 1 write, 2 read
        int addr;
    } vec_t;

    logic clk;
    logic reset;
    ddr2_ring_scheduler_if bus();

    ddr2_ring_scheduler #(
        .BURST_LEN     (2),
        .FIFO_SIZE     (2048),
        .RING_BYTES    (RING),
        .MAX_WR_STREAK (16),
        .TIMEOUT       (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  n_go  = 0;
    int  done_cnt = 0;
    bit  hold_done = 1'b0;
    go_t exp_q[$];
    vec_t vt[10];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input bit wr, input int a);
        go_t g;
        g.wr   = wr;
        g.addr = ADDR_W'(a);
        exp_q.push_back(g);
    endtask

    // One clock: models the burst engine (burst_done 4 edges after a go)
    // and scores every go pulse against the expected queue.
    task automatic tick();
        go_t e;
        @(negedge clk);
        cyc++;
        bus.burst_done = 1'b0;
        if (reset) begin
            done_cnt = 0;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0 && !hold_done) bus.burst_done = 1'b1;
        end
        if (bus.go_wr || bus.go_rd) begin
            n_go++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL go_unexpected actual wr=%0d addr=%0d required none",
                         bus.go_wr, bus.go_addr);
            end else begin
                e = exp_q.pop_front();
                check("go_kind_wr", int'(bus.go_wr), int'(e.wr));
                check("go_kind_rd", int'(bus.go_rd), int'(!e.wr));
                check("go_addr", int'(bus.go_addr), int'(e.addr));
            end
            done_cnt = 3;
        end
    endtask

    task automatic wait_go(input int target, input int budget);
        int n;
        n = 0;
        while (n_go < target && n < budget) begin
            tick();
            n++;
        end
        check("go_count", n_go, target);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", int'(bus.busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.calib_done = 1'b0;
        bus.writes_en  = 1'b0;
        bus.reads_en   = 1'b0;
        bus.ring_clear = 1'b0;
        bus.ib_count   = '0;
        bus.ob_count   = '0;
        hold_done      = 1'b0;
        tick();
        tick();
        exp_q.delete();
        n_go  = 0;
        reset = 1'b0;
    endtask

    task automatic fill(input int k);
        bus.calib_done = 1'b1;
        bus.writes_en  = 1'b1;
        bus.reads_en   = 1'b0;
        bus.ib_count   = 11'd100;
        bus.ob_count   = 11'd0;
        for (int i = 0; i < k; i++) push(1'b1, 8 * i);
        wait_go(n_go + k, 10 * k + 10);
        bus.writes_en = 1'b0;
        wait_idle(20);
        tick();
        tick();
    endtask

    initial begin
        int base;
        int prev;

        reset          = 1'b1;
        bus.calib_done = 1'b0;
        bus.writes_en  = 1'b0;
        bus.reads_en   = 1'b0;
        bus.ring_clear = 1'b0;
        bus.ib_count   = '0;
        bus.ob_count   = '0;
        bus.burst_done = 1'b0;

        //       calib we  re  ib   ob    fill kind addr
        vt[0] = '{1'b0, 1'b1, 1'b0, 100, 0,    0, 0, 0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 100, 0,    0, 1, 0};
        vt[2] = '{1'b1, 1'b1, 1'b0, 2,   0,    0, 1, 0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 1,   0,    0, 0, 0};
        vt[4] = '{1'b1, 1'b0, 1'b1, 0,   0,    0, 0, 0};
        vt[5] = '{1'b1, 1'b0, 1'b1, 0,   0,    1, 2, 0};
        vt[6] = '{1'b1, 1'b0, 1'b1, 0,   2044, 1, 2, 0};
        vt[7] = '{1'b1, 1'b0, 1'b1, 0,   2045, 1, 0, 0};
        vt[8] = '{1'b0, 1'b0, 1'b1, 0,   0,    1, 0, 0};
        vt[9] = '{1'b1, 1'b1, 1'b1, 100, 0,    1, 1, 8};

        // Reset state
        do_reset();
        check("rst_go_wr", int'(bus.go_wr), 0);
        check("rst_go_rd", int'(bus.go_rd), 0);
        check("rst_go_addr", int'(bus.go_addr), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_wptr", int'(bus.cmd_byte_addr_wr), 0);
        check("rst_rptr", int'(bus.cmd_byte_addr_rd), 0);
        check("rst_occ", int'(bus.occupancy), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_timeout", int'(bus.timeout_err), 0);

        // Eligibility table
        for (int v = 0; v < 10; v++) begin
            do_reset();
            fill(vt[v].fill);
            base = n_go;
            bus.calib_done = vt[v].calib;
            bus.writes_en  = vt[v].we;
            bus.reads_en   = vt[v].re;
            bus.ib_count   = 11'(vt[v].ib);
            bus.ob_count   = 11'(vt[v].ob);
            if (vt[v].kind != 0) push(vt[v].kind == 1, vt[v].addr);
            repeat (5) tick();
            bus.writes_en = 1'b0;
            bus.reads_en  = 1'b0;
            check($sformatf("vec%0d_gos", v), n_go - base, (vt[v].kind != 0) ? 1 : 0);
            wait_idle(20);
        end

        // Write-only streaming
        do_reset();
        bus.calib_done = 1'b1;
        bus.ib_count   = 11'd100;
        bus.writes_en  = 1'b1;
        for (int i = 0; i < 6; i++) push(1'b1, 8 * i);
        prev = 0;
        for (int i = 1; i <= 6; i++) begin
            wait_go(i, 20);
            check("wo_occ", int'(bus.occupancy), 8 * (i - 1));
            check("wo_wptr", int'(bus.cmd_byte_addr_wr), 8 * i);
            if (i > 1) check("wo_gap", cyc - prev, 5);
            prev = cyc;
        end
        bus.writes_en = 1'b0;
        wait_idle(20);
        tick();
        check("wo_occ_end", int'(bus.occupancy), 48);

        // Fairness: 16 writes, a forced read, then writes again
        do_reset();
        bus.calib_done = 1'b1;
        bus.ib_count   = 11'd100;
        bus.ob_count   = 11'd0;
        bus.writes_en  = 1'b1;
        bus.reads_en   = 1'b1;
        for (int i = 0; i < 16; i++) push(1'b1, 8 * i);
        push(1'b0, 0);
        push(1'b1, 128);
        push(1'b1, 136);
        wait_go(19, 150);
        bus.writes_en = 1'b0;
        bus.reads_en  = 1'b0;
        wait_idle(20);
        tick();
        tick();
        check("fair_occ", int'(bus.occupancy), 136);
        check("fair_rptr", int'(bus.cmd_byte_addr_rd), 8);
        check("fair_wptr", int'(bus.cmd_byte_addr_wr), 144);

        // Wrap, full ring, overflow, drain, clear
        do_reset();
        bus.calib_done = 1'b1;
        bus.ib_count   = 11'd10;
        bus.ob_count   = 11'd0;
        bus.writes_en  = 1'b1;
        for (int i = 0; i < 32; i++) push(1'b1, 8 * i);
        wait_go(32, 200);
        repeat (10) tick();
        check("full_blocked", n_go, 32);
        check("full_occ", int'(bus.occupancy), 256);
        check("full_wptr_wrapped", int'(bus.cmd_byte_addr_wr), 0);
        check("full_overflow", int'(bus.overflow), 1);
        check("full_busy", int'(bus.busy), 0);
        push(1'b0, 0);
        push(1'b1, 0);
        bus.reads_en = 1'b1;
        wait_go(34, 30);
        bus.writes_en = 1'b0;
        for (int i = 1; i < 32; i++) push(1'b0, 8 * i);
        push(1'b0, 0);
        wait_go(66, 250);
        wait_idle(20);
        repeat (3) tick();
        check("drain_gos", n_go, 66);
        check("drain_occ", int'(bus.occupancy), 0);
        check("drain_rptr", int'(bus.cmd_byte_addr_rd), 8);
        check("drain_wptr", int'(bus.cmd_byte_addr_wr), 8);
        check("drain_overflow_sticky", int'(bus.overflow), 1);
        bus.ring_clear = 1'b1;
        tick();
        bus.ring_clear = 1'b0;
        check("clr_occ", int'(bus.occupancy), 0);
        check("clr_wptr", int'(bus.cmd_byte_addr_wr), 0);
        check("clr_rptr", int'(bus.cmd_byte_addr_rd), 0);
        check("clr_overflow", int'(bus.overflow), 0);
        repeat (6) tick();
        check("clr_no_read", n_go, 66);
        bus.reads_en = 1'b0;

        // ring_clear while busy is held until after burst_done
        do_reset();
        bus.calib_done = 1'b1;
        bus.ib_count   = 11'd100;
        bus.writes_en  = 1'b1;
        push(1'b1, 0);
        wait_go(1, 10);
        bus.writes_en  = 1'b0;
        bus.ring_clear = 1'b1;
        tick();
        bus.ring_clear = 1'b0;
        wait_idle(10);
        check("pend_occ_before", int'(bus.occupancy), 8);
        check("pend_wptr_before", int'(bus.cmd_byte_addr_wr), 8);
        tick();
        check("pend_occ_after", int'(bus.occupancy), 0);
        check("pend_wptr_after", int'(bus.cmd_byte_addr_wr), 0);

        // Watchdog on a read whose burst_done never comes
        do_reset();
        fill(1);
        hold_done      = 1'b1;
        bus.reads_en   = 1'b1;
        bus.ob_count   = 11'd0;
        push(1'b0, 0);
        wait_go(2, 10);
        bus.reads_en = 1'b0;
        repeat (TMO - 1) tick();
        check("wd_err_early", int'(bus.timeout_err), 0);
        check("wd_busy_early", int'(bus.busy), 1);
        tick();
        check("wd_err", int'(bus.timeout_err), 1);
        check("wd_busy", int'(bus.busy), 0);
        check("wd_occ", int'(bus.occupancy), 0);
        hold_done = 1'b0;

        // Asynchronous reset in the middle of a write burst
        do_reset();
        bus.calib_done = 1'b1;
        bus.ib_count   = 11'd100;
        bus.writes_en  = 1'b1;
        push(1'b1, 0);
        push(1'b1, 8);
        wait_go(2, 20);
        #1;
        reset = 1'b1;
        #1;
        check("ar_go_wr", int'(bus.go_wr), 0);
        check("ar_go_addr", int'(bus.go_addr), 0);
        check("ar_busy", int'(bus.busy), 0);
        check("ar_wptr", int'(bus.cmd_byte_addr_wr), 0);
        check("ar_occ", int'(bus.occupancy), 0);
        tick();
        tick();
        exp_q.delete();
        n_go  = 0;
        reset = 1'b0;
        push(1'b1, 0);
        wait_go(1, 10);
        bus.writes_en = 1'b0;
        wait_idle(20);
        check("ar_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

endmodule
